// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and reports the WIDTH-bit difference and the final borrow with a done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q;

  logic accept, last_bit, ai, bi, d_bit, br_next;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign ai       = a_q[0];
  assign bi       = b_q[0];
  assign d_bit    = ai ^ bi ^ br_q;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operands shift right so bit 0 is always the current bit; the result
  // enters from the MSB side and lands in place after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      br_q   <= br_next;
      diff_q <= {d_bit, diff_q[WIDTH-1:1]};
      if (last_bit) bout_q <= br_next;
      else          cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor: an 8-bit instance for
// directed, random and back-to-back traffic, and a 2-bit instance swept exhaustively.
module tb_serial_subtractor;

  typedef struct {
    int d;
    int bo;
    int c;
  } exp_t;

  logic       clk, rst_n;
  logic       start, bin, busy, done, bout;
  logic [7:0] a, b, diff;
  logic       start2, bin2, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;

  int   cyc = 0;
  int   nchk = 0, nfail = 0;
  int   free_cyc = 0, free2 = 0;
  int   last_done = -1;
  bit   b2b = 0;
  exp_t q[$], q2[$];

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int av, input int bv, input int bi,
                                 input int w, input int c);
    exp_t e;
    int   m;
    m    = 1 << w;
    e.d  = ((av - bv - bi) % m + m) % m;
    e.bo = (av < bv + bi) ? 1 : 0;
    e.c  = c;
    return e;
  endfunction

  // Drive a one-cycle start once the model says the 8-bit unit is idle.
  task automatic issue(input int av, input int bv, input int bi);
    while (cyc < free_cyc) @(negedge clk);
    a = av[7:0]; b = bv[7:0]; bin = bi[0]; start = 1;
    q.push_back(model(av, bv, bi, 8, cyc + 1 + 8));
    free_cyc = cyc + 10;
    @(negedge clk);
    start = 0;
  endtask

  task automatic issue2(input int av, input int bv, input int bi);
    while (cyc < free2) @(negedge clk);
    a2 = av[1:0]; b2 = bv[1:0]; bin2 = bi[0]; start2 = 1;
    q2.push_back(model(av, bv, bi, 2, cyc + 1 + 2));
    free2 = cyc + 4;
    @(negedge clk);
    start2 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || q2.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", q.size() + q2.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("diff", int'(diff), e.d);
          chk("bout", int'(bout), e.bo);
          chk("done_cycle", cyc, e.c);
        end
        if (b2b && last_done >= 0) chk("done_spacing", cyc - last_done, 10);
        last_done = cyc;
      end
      if (done2) begin
        if (q2.size() == 0) chk("unexpected_done_w2", 1, 0);
        else begin
          exp_t e;
          e = q2.pop_front();
          chk("diff_w2", int'(diff2), e.d);
          chk("bout_w2", int'(bout2), e.bo);
          chk("done_cycle_w2", cyc, e.c);
        end
      end
    end
  end

  initial begin
    int bcnt;
    rst_n = 0; start = 0; a = 0; b = 0; bin = 0;
    start2 = 0; a2 = 0; b2 = 0; bin2 = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // First op with busy-length measurement.
    issue(8'h5A, 8'h3C, 0);
    bcnt = 0;
    repeat (12) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("busy_cycles", bcnt, 8);

    issue(8'h00, 8'h01, 0);
    issue(8'h80, 8'h7F, 1);
    issue(8'hFF, 8'hFF, 1);
    issue(8'hFF, 8'h00, 0);

    // Start pulsed during SHIFT must be ignored.
    issue(8'hC3, 8'h41, 1);
    @(negedge clk); @(negedge clk);
    a = 8'h12; b = 8'hEE; bin = 0; start = 1;
    @(negedge clk);
    start = 0;
    drain();

    // Reset in the middle of SHIFT: outputs clear at once, no done follows.
    issue(8'h9D, 8'h27, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    free_cyc = 0;
    repeat (15) @(negedge clk);
    issue(8'h9D, 8'h27, 0);
    drain();

    // Random single-shot ops with random gaps.
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
    end
    drain();

    // Start held high: one result every 10 cycles.
    b2b = 1;
    last_done = -1;
    repeat (1000) begin
      while (cyc < free_cyc) @(negedge clk);
      begin
        int av, bv, bi;
        av = $urandom_range(0, 255); bv = $urandom_range(0, 255); bi = $urandom_range(0, 1);
        a = av[7:0]; b = bv[7:0]; bin = bi[0]; start = 1;
        q.push_back(model(av, bv, bi, 8, cyc + 1 + 8));
        free_cyc = cyc + 10;
      end
      @(negedge clk);
    end
    start = 0;
    drain();
    b2b = 0;

    // Exhaustive sweep of the 2-bit instance.
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue2(ia, ib, ic);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
